// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C target
package i2c_pkg;

    localparam int   I2C_BYTE_WD = 8;
    localparam logic ACK         = 1'b0;
    localparam logic NACK        = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR,
        WR_ACK,
        RD,
        RD_ACK
    } i2c_tgt_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchroniser, optional glitch filter (I2C_TGT_GLITCH_FILTER_EN), bus event detection
module i2c_bus_sync
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_f;
    logic       sda_f;
    logic       scl_prev_q;
    logic       sda_prev_q;

    // Two-flop synchronisers; reset to the idle-high bus level so no edge appears after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
        end
    end

`ifdef I2C_TGT_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q;
    logic [1:0] sda_hist_q;
    logic       scl_filt_q;
    logic       sda_filt_q;

    // Majority of three consecutive samples: a single-clk pulse never wins two votes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
            scl_filt_q <= maj3(scl_sync_q[1], scl_hist_q[0], scl_hist_q[1]);
            sda_filt_q <= maj3(sda_sync_q[1], sda_hist_q[0], sda_hist_q[1]);
        end
    end

    assign scl_f = scl_filt_q;
    assign sda_f = sda_filt_q;
`else
    assign scl_f = scl_sync_q[1];
    assign sda_f = sda_sync_q[1];
`endif

    // One-clk delayed copies for edge and condition detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_f;
            sda_prev_q <= sda_f;
        end
    end

    assign sda_s     = sda_f;
    assign scl_rise  = scl_f & ~scl_prev_q;
    assign scl_fall  = ~scl_f & scl_prev_q;
    assign start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
    assign stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;

endmodule

// File: rtl/i2c_target_mem.sv
// rtl/i2c_target_mem.sv - I2C target with pointer-addressed register memory; glitch filter via I2C_TGT_GLITCH_FILTER_EN
module i2c_target_mem
    import i2c_pkg::*;
#(
    parameter int         DATA_WD  = 8,
    parameter int         DEPTH    = 128,
    parameter int         PTR_WD   = $clog2(DEPTH),
    parameter logic [6:0] DEV_ADDR = 7'h50
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               scl_i,
    input  logic               sda_i,
    output logic               sda_oe,
    output logic               busy,
    output logic               wr_strobe,
    output logic [PTR_WD-1:0]  wr_addr,
    output logic [DATA_WD-1:0] wr_data
);

    if (DATA_WD != I2C_BYTE_WD) begin : g_data_wd_chk
        $error("i2c_target_mem: DATA_WD must be 8");
    end
    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("i2c_target_mem: DEPTH must be a power of 2 in 2..256");
    end

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    i2c_tgt_state_e           state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [I2C_BYTE_WD-1:0]   shift_q, shift_d;
    logic [PTR_WD-1:0]        ptr_q, ptr_d;
    logic                     sda_oe_q, sda_oe_d;
    logic                     busy_q, busy_d;
    logic                     wr_strobe_q, wr_strobe_d;
    logic [PTR_WD-1:0]        wr_addr_q, wr_addr_d;
    logic [DATA_WD-1:0]       wr_data_q, wr_data_d;
    logic                     mem_we;
    logic [I2C_BYTE_WD-1:0]   mem_q [DEPTH];

    logic [I2C_BYTE_WD-1:0]   byte_in;
    logic                     byte_done;
    logic                     bus_cond;

    assign byte_in   = {shift_q[I2C_BYTE_WD-2:0], sda_s};
    assign byte_done = scl_rise && (cnt_q == 4'd7);
    assign bus_cond  = start_det | stop_det;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state: START/STOP override everything; ACK phases end on the SCL fall after the ninth rise
    always_comb begin
        state_d = state_q;
        if (stop_det) begin
            state_d = IDLE;
        end else if (start_det) begin
            state_d = ADDR;
        end else begin
            case (state_q)
                ADDR:     if (byte_done) state_d = (byte_in[7:1] == DEV_ADDR) ? ADDR_ACK : IDLE;
                ADDR_ACK: if (scl_fall && cnt_q == 4'd1) state_d = shift_q[0] ? RD : PTR;
                PTR:      if (byte_done) state_d = PTR_ACK;
                PTR_ACK:  if (scl_fall && cnt_q == 4'd1) state_d = WR;
                WR:       if (byte_done) state_d = WR_ACK;
                WR_ACK:   if (scl_fall && cnt_q == 4'd1) state_d = WR;
                RD:       if (scl_fall && cnt_q == 4'd8) state_d = RD_ACK;
                RD_ACK: begin
                    if (scl_rise && sda_s == NACK)          state_d = IDLE;
                    else if (scl_fall && cnt_q == 4'd1)     state_d = RD;
                end
                default:  state_d = state_q;
            endcase
        end
    end

    // Outputs and datapath next values; SDA only moves on an SCL fall
    always_comb begin
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        mem_we      = 1'b0;

        if (!bus_cond) begin
            case (state_q)
                ADDR: if (scl_rise) shift_d = byte_in;
                PTR: begin
                    if (scl_rise)  shift_d = byte_in;
                    if (byte_done) ptr_d = byte_in[PTR_WD-1:0];
                end
                WR: begin
                    if (scl_rise) shift_d = byte_in;
                    if (byte_done) begin
                        mem_we      = 1'b1;
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = ptr_q;
                        wr_data_d   = byte_in;
                        ptr_d       = ptr_q + 1'b1;
                    end
                end
                ADDR_ACK, PTR_ACK, WR_ACK: if (scl_fall) sda_oe_d = (cnt_q == 4'd0);
                RD: begin
                    if (scl_rise) shift_d = {shift_q[I2C_BYTE_WD-2:0], 1'b0};
                    if (scl_fall) sda_oe_d = (cnt_q == 4'd8) ? 1'b0 : ~shift_q[I2C_BYTE_WD-1];
                end
                default: ;
            endcase
        end

        // Entering RD fetches the byte at the pointer and presents its MSB
        if (state_d == RD && state_q != RD) begin
            shift_d  = mem_q[ptr_q];
            ptr_d    = ptr_q + 1'b1;
            sda_oe_d = ~mem_q[ptr_q][I2C_BYTE_WD-1];
        end

        if (bus_cond || state_d == IDLE) sda_oe_d = 1'b0;
        if (state_d == ADDR_ACK)         busy_d = 1'b1;
        else if (state_d == IDLE)        busy_d = 1'b0;

        if (state_d == IDLE || bus_cond || state_d != state_q) cnt_d = 4'd0;
        else if (scl_rise)                                    cnt_d = cnt_q + 4'd1;
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Register memory, cleared on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[ptr_q] <= byte_in;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: doc/i2c_target_mem.md
Name: i2c_target_mem

Overview:
- Parametrised I2C target with an on-chip register memory; successor to the single-byte memory target.
- Proper bus sampling and START/STOP/repeated-START detection, 7-bit device-address match with ACK/NACK.
- Pointer byte with auto-increment and wrap; multi-byte burst writes and reads.
- Sits behind the chip's open-drain pad cell. Exposes a write-notify side port to local logic.

Parameters:
- DATA_WD, 8, data byte width on the bus; fixed at 8 for I2C compliance, checked by elaboration assertion.
- DEPTH, 128, memory depth in bytes; power of 2, range 2..256.
- PTR_WD, $clog2(DEPTH), pointer width (derived; do not override).
- DEV_ADDR, 7'h50, 7-bit target address.

Ports:
- clk  in  1  system clock; must run at least 10x SCL frequency.
- rst  in  1  asynchronous, active-high reset. Single clock domain.
- scl_i  in  1  raw SCL from pad, asynchronous.
- sda_i  in  1  raw SDA from pad, asynchronous.
- sda_oe  out  1  1 = pull SDA low; pad drives 0 when set, else high-Z.
- busy  out  1  high from address-match ACK until STOP, non-matching restart, or read NACK.
- wr_strobe  out  1  one-clk pulse per memory byte written.
- wr_addr  out  PTR_WD  address of the byte written, valid with wr_strobe.
- wr_data  out  8  data of the byte written, valid with wr_strobe.

Behaviour:
- Reset: sda_oe=0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0, pointer=0, state=IDLE, all memory bytes cleared to 0.
- scl_i/sda_i pass through 2-flop synchronisers. Edges and conditions use the synced values and their 1-clk-delayed copies.
- START: SDA 1->0 while SCL=1. STOP: SDA 0->1 while SCL=1. Both are detected from any state and take priority over bit sampling in the same clk.
- Bits are sampled on SCL rise, MSB first. sda_oe changes only on the clk after an SCL fall. SDA is never changed while SCL is high.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK.
- IDLE: waits for START -> ADDR. Bit counter cleared.
- ADDR: shift 8 bits.
  - {addr[6:0]} == DEV_ADDR -> ADDR_ACK.
  - Mismatch -> IDLE with sda_oe=0; ignore bus until the next START.
- ADDR_ACK: sda_oe=1 for one SCL period. Then R/W=0 -> PTR, R/W=1 -> RD.
- PTR: shift 8 bits; pointer <= byte[PTR_WD-1:0] (upper bits ignored) -> PTR_ACK (ACK) -> WR.
- WR: shift 8 bits -> on 8th SCL rise:
  - mem[pointer] <= byte; wr_strobe pulses 1 clk with old pointer/byte.
  - pointer <= pointer+1 mod DEPTH.
  - -> WR_ACK (ACK) -> WR.
- RD: on entry (SCL fall), shift register <= mem[pointer] and pointer <= pointer+1 mod DEPTH. Drive sda_oe = ~bit (MSB first) on each SCL fall. After the 8th bit -> RD_ACK with sda_oe=0.
- RD_ACK: sample master bit on SCL rise.
  - 0 (ACK) -> RD, next byte.
  - 1 (NACK) -> IDLE, busy=0; wait for STOP/START.
- Repeated START in any state -> ADDR. Pointer is retained, giving the standard write-pointer-then-read sequence.
- STOP in any state -> IDLE, sda_oe=0, busy=0. A partial byte is discarded and memory is not written.
- Wrap: pointer DEPTH-1 +1 -> 0 for both reads and writes.
- Simultaneous wr_strobe with a local read is not applicable: memory is I2C-only.
- Reset asserted mid-transfer: immediate return to reset values; SDA is released asynchronously.

Optional Feature:
- Macro I2C_TGT_GLITCH_FILTER_EN.
- Defined: each synced line passes a 3-sample majority filter before edge detection. Pulses of 1 clk or shorter are rejected. Input latency becomes 4 clk instead of 2.
- Undefined: no filter; a 2-clk synchroniser only.

Decomposition:
- Package i2c_pkg: state enum i2c_tgt_state_e, I2C_BYTE_WD=8, ACK=1'b0 / NACK=1'b1 constants.
- Sub-module i2c_bus_sync: synchroniser, optional filter, and START/STOP/SCL rise/fall detection. Outputs one-clk pulses scl_rise, scl_fall, start_det, stop_det plus sda_s. Reusable by the future I2C controller.

Test Plan:
- Write burst: START, 0xA0, ptr 0x10, data 0x11,0x22,0x33, STOP.
  - Required: three ACKs; mem[0x10..0x12] = 11,22,33.
  - Required: wr_strobe x3 with wr_addr 0x10,0x11,0x12.
- Random read: START, 0xA0, ptr 0x10, repeated START, 0xA1, read 3 bytes (ACK, ACK, NACK), STOP.
  - Required: SDA returns 0x11,0x22,0x33; busy falls after the NACK.
- Address mismatch: START, 0xA2, byte 0x55, STOP.
  - Required: no ACK (sda_oe stays 0 throughout); memory unchanged; busy=0.
- Wrap: ptr 0x7F, write 0xAA,0xBB (DEPTH=128).
  - Required: mem[0x7F]=AA, mem[0x00]=BB.
  - Required: subsequent read from 0x7F returns AA then BB.
- Abort: STOP after 4 data bits of a write byte.
  - Required: no wr_strobe; memory unchanged; sda_oe=0; state IDLE.
  - Then assert rst mid-read: sda_oe=0 and busy=0 immediately.
- Glitch (I2C_TGT_GLITCH_FILTER_EN defined): 1-clk SDA low pulse while SCL high.
  - Required: no START detected.
  - Required with the macro undefined: START detected.
